// File: rtl/tempsense_vdac_ctrl.sv
// tempsense_vdac_ctrl
//   Successive-approximation / continuous-tracking controller for the
//   temperature-sensor voltage DAC. Drives the DAC code and enable, samples
//   an external comparator through a 2-flop synchronizer and reports a
//   BITWIDTH-bit temperature code.
//
// Ports
//   clk          block clock
//   rst_n        asynchronous active-low reset
//   start        1-cycle pulse, begins a conversion when idle
//   stop         1-cycle pulse, aborts SAR or ends tracking (wins over start)
//   mode         0 = SAR single-shot, 1 = tracking; sampled on accepted start
//   comp_in      async comparator, 1 = DAC below sensed voltage (code rises)
//   dac_data     code to the vdac (offset binary, MSB = sign cell)
//   dac_enable   vdac enable, high while busy
//   busy         conversion or tracking in progress
//   result       last completed code
//   result_valid 1-cycle pulse when result updates
//   saturated    last tracking step was clamped at 0 or all-ones
module tempsense_vdac_ctrl #(
  parameter int unsigned BITWIDTH      = 6,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                mode,
  input  logic                comp_in,
  output logic [BITWIDTH-1:0] dac_data,
  output logic                dac_enable,
  output logic                busy,
  output logic [BITWIDTH-1:0] result,
  output logic                result_valid,
  output logic                saturated
);

  localparam int unsigned          IW          = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;
  localparam logic [BITWIDTH-1:0]  ONE         = BITWIDTH'(1);
  localparam logic [BITWIDTH-1:0]  MID         = BITWIDTH'(1) << (BITWIDTH - 1);
  localparam logic [3:0]           SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0]        TOP_IDX     = IW'(BITWIDTH - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, DECIDE, DONE} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic                mode_r, mode_nxt;
  logic [BITWIDTH-1:0] dac_nxt, result_nxt;
  logic                valid_nxt, sat_nxt;
  logic                comp_meta, comp_sync;
  logic [BITWIDTH-1:0] sar_code, trk_code;
  logic                trk_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      mode_r       <= 1'b0;
      dac_data     <= MID;
      result       <= MID;
      result_valid <= 1'b0;
      saturated    <= 1'b0;
      comp_meta    <= 1'b0;
      comp_sync    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      mode_r       <= mode_nxt;
      dac_data     <= dac_nxt;
      result       <= result_nxt;
      result_valid <= valid_nxt;
      saturated    <= sat_nxt;
      comp_meta    <= comp_in;
      comp_sync    <= comp_meta;
    end
  end

  assign busy       = (state != IDLE);
  assign dac_enable = busy;

  always_comb begin
    // SAR trial update: resolve the current bit, then arm the next lower one.
    sar_code = dac_data;
    if (!comp_sync) sar_code[idx] = 1'b0;
    if (idx != '0)  sar_code[idx - IW'(1)] = 1'b1;

    // Tracking step with clamping at both ends of the code range.
    trk_sat  = 1'b0;
    trk_code = dac_data;
    if (comp_sync) begin
      if (&dac_data) trk_sat  = 1'b1;
      else           trk_code = dac_data + ONE;
    end else begin
      if (dac_data == '0) trk_sat  = 1'b1;
      else                trk_code = dac_data - ONE;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    mode_nxt   = mode_r;
    dac_nxt    = dac_data;
    result_nxt = result;
    valid_nxt  = 1'b0;
    sat_nxt    = saturated;

    case (state)
      IDLE: begin
        if (start && !stop) begin
          mode_nxt  = mode;
          state_nxt = SETTLE;
          cnt_nxt   = SETTLE_LOAD;
          sat_nxt   = 1'b0;
          if (mode) begin
            dac_nxt = result;
          end else begin
            dac_nxt = MID;
            idx_nxt = TOP_IDX;
          end
        end
      end
      SETTLE: begin
        if (cnt == '0) state_nxt = DECIDE;
        else           cnt_nxt   = cnt - 4'd1;
      end
      DECIDE: begin
        state_nxt = SETTLE;
        cnt_nxt   = SETTLE_LOAD;
        if (mode_r) begin
          dac_nxt    = trk_code;
          result_nxt = trk_code;
          valid_nxt  = 1'b1;
          sat_nxt    = trk_sat;
        end else begin
          dac_nxt = sar_code;
          if (idx != '0) idx_nxt   = idx - IW'(1);
          else           state_nxt = DONE;
        end
      end
      DONE: begin
        result_nxt = dac_data;
        valid_nxt  = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Abort overrides whatever the state logic above decided, including a
    // concurrent DECIDE, so every datapath register simply holds.
    if (stop && state != IDLE) begin
      state_nxt  = IDLE;
      cnt_nxt    = cnt;
      idx_nxt    = idx;
      mode_nxt   = mode_r;
      dac_nxt    = dac_data;
      result_nxt = result;
      valid_nxt  = 1'b0;
      sat_nxt    = saturated;
    end
  end

endmodule

// File: tb/tb_tempsense_vdac_ctrl.sv
module tb_tempsense_vdac_ctrl;

  localparam int B    = 6;
  localparam int S    = 4;
  localparam int P    = S + 1;
  localparam int LAT  = B * P + 1;
  localparam int MAXC = (1 << B) - 1;
  localparam int MIDC = 1 << (B - 1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         mode = 1'b0;
  logic         comp_in;
  logic [B-1:0] dac_data;
  logic         dac_enable;
  logic         busy;
  logic [B-1:0] result;
  logic         result_valid;
  logic         saturated;

  int n_cmp = 0;
  int n_err = 0;

  // Comparator model: 0 = threshold (code <= thr means code must rise),
  // 1 = tied high, 2 = tied low.
  int cmode = 0;
  int thr = 0;
  assign comp_in = (cmode == 0) ? (int'(dac_data) <= thr) : (cmode == 1);

  // Reference state
  int m_result = MIDC;
  int m_code = MIDC;
  bit m_sat = 1'b0;

  tempsense_vdac_ctrl #(.BITWIDTH(B), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .comp_in(comp_in), .dac_data(dac_data), .dac_enable(dac_enable),
    .busy(busy), .result(result), .result_valid(result_valid),
    .saturated(saturated)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Binary search: trial j keeps the already-resolved upper bits of the
  // answer and sets the bit under test.
  function automatic logic [B-1:0] sar_trial(input int res, input int j);
    int mask;
    mask = ~((1 << (B - j)) - 1);
    return B'((res & mask) | (1 << (B - 1 - j)));
  endfunction

  function automatic int sar_expect(input int cm, input int t);
    if (cm == 1) return MAXC;
    if (cm == 2) return 0;
    if (t < 0) return 0;
    if (t > MAXC) return MAXC;
    return t;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #17;
    n_cmp++; if (dac_data !== B'(MIDC)) begin n_err++; $display("FAIL reset_dac got %0d want %0d", dac_data, MIDC); end
    n_cmp++; if (result !== B'(MIDC)) begin n_err++; $display("FAIL reset_result got %0d want %0d", result, MIDC); end
    n_cmp++; if ({busy, dac_enable, result_valid, saturated} !== 4'b0000) begin n_err++; $display("FAIL reset_flags got %b want 0000", {busy, dac_enable, result_valid, saturated}); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({busy, dac_enable, result_valid} !== 3'b000) begin n_err++; $display("FAIL reset_idle got %b want 000", {busy, dac_enable, result_valid}); end
    end
  endtask

  task automatic test_sar(input int cm, input int t, input bit poke_start, input string tag);
    int e;
    logic [B-1:0] ed;
    cmode = cm;
    thr = t;
    e = sar_expect(cm, t);
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0; mode = 1'($urandom_range(0, 1));
    n_cmp++; if (dac_data !== B'(MIDC)) begin n_err++; $display("FAIL %s first_trial got %0d want %0d", tag, dac_data, MIDC); end
    n_cmp++; if ({busy, dac_enable, saturated} !== 3'b110) begin n_err++; $display("FAIL %s start_flags got %b want 110", tag, {busy, dac_enable, saturated}); end
    for (int k = 1; k <= LAT; k++) begin
      if (poke_start && k == 12) start = 1'b1;
      tick();
      start = 1'b0;
      ed = (k < B * P) ? sar_trial(e, k / P) : B'(e);
      n_cmp++; if (dac_data !== ed) begin n_err++; $display("FAIL %s dac@%0d got %0d want %0d", tag, k, dac_data, ed); end
      n_cmp++; if (busy !== 1'(k < LAT)) begin n_err++; $display("FAIL %s busy@%0d got %b want %b", tag, k, busy, k < LAT); end
      n_cmp++; if (result_valid !== 1'(k == LAT)) begin n_err++; $display("FAIL %s valid@%0d got %b want %b", tag, k, result_valid, k == LAT); end
    end
    n_cmp++; if (result !== B'(e)) begin n_err++; $display("FAIL %s result got %0d want %0d", tag, result, e); end
    n_cmp++; if (dac_enable !== 1'b0) begin n_err++; $display("FAIL %s enable_idle got %b want 0", tag, dac_enable); end
    m_result = e;
    tick();
    n_cmp++; if ({result_valid, busy} !== 2'b00) begin n_err++; $display("FAIL %s after_done got %b want 00", tag, {result_valid, busy}); end
  endtask

  task automatic test_sar_abort();
    int e;
    logic [B-1:0] ed;
    cmode = 0;
    thr = $urandom_range(0, MAXC);
    e = sar_expect(0, thr);
    ed = sar_trial(e, 1);
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++; if ({busy, dac_enable, result_valid} !== 3'b000) begin n_err++; $display("FAIL abort_flags got %b want 000", {busy, dac_enable, result_valid}); end
    n_cmp++; if (result !== B'(m_result)) begin n_err++; $display("FAIL abort_result got %0d want %0d", result, m_result); end
    n_cmp++; if (dac_data !== ed) begin n_err++; $display("FAIL abort_dac_hold got %0d want %0d", dac_data, ed); end
    for (int i = 0; i < 40; i++) begin
      tick();
      n_cmp++; if ({busy, result_valid} !== 2'b00) begin n_err++; $display("FAIL abort_quiet@%0d got %b want 00", i, {busy, result_valid}); end
    end
  endtask

  task automatic test_start_stop_collision();
    @(posedge clk); #1;
    start = 1'b1; stop = 1'b1; mode = 1'($urandom_range(0, 1));
    tick();
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if ({busy, dac_enable, result_valid} !== 3'b000) begin n_err++; $display("FAIL collision@%0d got %b want 000", i, {busy, dac_enable, result_valid}); end
      tick();
    end
    n_cmp++; if (result !== B'(m_result)) begin n_err++; $display("FAIL collision_result got %0d want %0d", result, m_result); end
  endtask

  task automatic track_start(input string tag);
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b1;
    tick();
    start = 1'b0; mode = 1'b0;
    m_code = m_result;
    m_sat = 1'b0;
    n_cmp++; if (dac_data !== B'(m_code)) begin n_err++; $display("FAIL %s track_load got %0d want %0d", tag, dac_data, m_code); end
    n_cmp++; if ({busy, dac_enable, saturated, result_valid} !== 4'b1100) begin n_err++; $display("FAIL %s track_flags got %b want 1100", tag, {busy, dac_enable, saturated, result_valid}); end
  endtask

  task automatic track_steps(input int n, input string tag);
    bit up;
    for (int s = 0; s < n; s++) begin
      for (int c = 1; c <= P; c++) begin
        if (c == P) begin
          up = (cmode == 0) ? (m_code <= thr) : (cmode == 1);
          if (up) begin
            if (m_code == MAXC) m_sat = 1'b1;
            else begin m_code++; m_sat = 1'b0; end
          end else begin
            if (m_code == 0) m_sat = 1'b1;
            else begin m_code--; m_sat = 1'b0; end
          end
        end
        tick();
        n_cmp++; if (result_valid !== 1'(c == P)) begin n_err++; $display("FAIL %s tvalid s%0d c%0d got %b want %b", tag, s, c, result_valid, c == P); end
        n_cmp++; if (dac_data !== B'(m_code)) begin n_err++; $display("FAIL %s tdac s%0d c%0d got %0d want %0d", tag, s, c, dac_data, m_code); end
      end
      m_result = m_code;
      n_cmp++; if (result !== B'(m_code)) begin n_err++; $display("FAIL %s tresult s%0d got %0d want %0d", tag, s, result, m_code); end
      n_cmp++; if (saturated !== m_sat) begin n_err++; $display("FAIL %s tsat s%0d got %b want %b", tag, s, saturated, m_sat); end
    end
  endtask

  task automatic track_stop(input int extra, input string tag);
    for (int i = 1; i < extra; i++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++; if ({busy, dac_enable, result_valid} !== 3'b000) begin n_err++; $display("FAIL %s tstop_flags got %b want 000", tag, {busy, dac_enable, result_valid}); end
    n_cmp++; if (result !== B'(m_result)) begin n_err++; $display("FAIL %s tstop_result got %0d want %0d", tag, result, m_result); end
    n_cmp++; if (dac_data !== B'(m_code)) begin n_err++; $display("FAIL %s tstop_dac got %0d want %0d", tag, dac_data, m_code); end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if ({busy, result_valid} !== 2'b00) begin n_err++; $display("FAIL %s tstop_quiet@%0d got %b want 00", tag, i, {busy, result_valid}); end
    end
  endtask

  task automatic test_tracking_basic();
    cmode = 0;
    thr = 35;
    track_start("trk35");
    track_steps(6, "trk35");
    n_cmp++; if ({result, saturated} !== {6'd36, 1'b0}) begin n_err++; $display("FAIL trk35_final got %0d/%b want 36/0", result, saturated); end
    track_stop($urandom_range(1, P), "trk35");
  endtask

  task automatic test_saturation();
    test_sar(0, 62, 1'b0, "sat_prep_hi");
    cmode = 1;
    track_start("sat_hi");
    track_steps(3, "sat_hi");
    cmode = 2;
    track_steps(1, "sat_hi_back");
    n_cmp++; if ({result, saturated} !== {6'd62, 1'b0}) begin n_err++; $display("FAIL sat_hi_release got %0d/%b want 62/0", result, saturated); end
    track_stop(P, "sat_hi");
    test_sar(0, 1, 1'b0, "sat_prep_lo");
    cmode = 2;
    track_start("sat_lo");
    track_steps(2, "sat_lo");
    n_cmp++; if ({result, saturated} !== {6'd0, 1'b1}) begin n_err++; $display("FAIL sat_lo_clamp got %0d/%b want 0/1", result, saturated); end
    track_stop($urandom_range(1, P), "sat_lo");
  endtask

  task automatic test_tracking_random();
    cmode = 0;
    thr = $urandom_range(0, MAXC);
    track_start("trk_rand");
    for (int r = 0; r < 5; r++) begin
      cmode = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      thr = $urandom_range(0, MAXC);
      track_steps($urandom_range(2, 6), "trk_rand");
    end
    track_stop($urandom_range(1, P), "trk_rand");
  endtask

  task automatic test_reset_mid();
    cmode = 0;
    thr = $urandom_range(0, MAXC);
    track_start("rst_mid");
    track_steps(2, "rst_mid");
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (dac_data !== B'(MIDC)) begin n_err++; $display("FAIL rst_mid_dac got %0d want %0d", dac_data, MIDC); end
    n_cmp++; if (result !== B'(MIDC)) begin n_err++; $display("FAIL rst_mid_result got %0d want %0d", result, MIDC); end
    n_cmp++; if ({busy, dac_enable, result_valid, saturated} !== 4'b0000) begin n_err++; $display("FAIL rst_mid_flags got %b want 0000", {busy, dac_enable, result_valid, saturated}); end
    m_result = MIDC;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if ({busy, dac_enable, result_valid} !== 3'b000) begin n_err++; $display("FAIL rst_mid_quiet@%0d got %b want 000", i, {busy, dac_enable, result_valid}); end
    end
    test_sar(0, $urandom_range(0, MAXC), 1'b0, "rst_mid_sar");
  endtask

  initial begin
    test_reset();
    test_tracking_basic();
    test_sar(0, 37, 1'b0, "sar37");
    test_sar(0, 37, 1'b1, "sar37_busy_start");
    test_sar(1, 0, 1'b0, "sar_tie1");
    test_sar(2, 0, 1'b0, "sar_tie0");
    test_sar_abort();
    test_start_stop_collision();
    test_saturation();
    for (int i = 0; i < 6; i++) test_sar(0, int'($urandom_range(0, MAXC + 8)) - 4, 1'($urandom_range(0, 1)), "sar_rand");
    test_tracking_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tempsense_vdac_ctrl.md
Name: tempsense_vdac_ctrl

Overview:
Parametrised successive-approximation and tracking controller for the temperature-sensor voltage DAC. It drives the DAC code word and enable, and samples an external comparator that compares the sensed voltage against the DAC output. It returns a BITWIDTH-bit temperature code. It sits between the digital register interface (start/stop/mode/result) and the vdac analog macro plus comparator.

Parameters:
BITWIDTH, 6, width of the DAC code and result; the DAC code is offset binary (MSB = sign cell).
SETTLE_CYCLES, 4, wait cycles after each DAC code change before the comparator is sampled; legal range 2..15.

Ports:
clk  input  1  block clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins a conversion when idle
stop  input  1  single-cycle pulse; aborts SAR or ends tracking
mode  input  1  0 = SAR single-shot, 1 = continuous tracking; sampled only when start is accepted
comp_in  input  1  asynchronous comparator output; 1 = DAC output below sensed voltage (code must rise)
dac_data  output  BITWIDTH  code to the vdac
dac_enable  output  1  vdac enable
busy  output  1  conversion or tracking in progress
result  output  BITWIDTH  last completed code
result_valid  output  1  one-cycle pulse when result updates
saturated  output  1  last tracking step was clamped at 0 or all-ones

Behaviour:
- Reset (async assert, sync release):
  - dac_data = result = 1<<(BITWIDTH-1) (100..0).
  - busy = dac_enable = result_valid = saturated = 0.
  - FSM in IDLE; comparator synchronizer flops cleared.
- comp_in passes through a 2-flop synchronizer. The decision uses the synchronized value. SETTLE_CYCLES ≥ 2 covers the synchronizer delay.
- FSM states: IDLE, SETTLE, DECIDE, DONE.
- IDLE:
  - busy = 0 and dac_enable = 0; dac_data holds its last value.
  - start=1 and stop=0: latch mode, go to SETTLE, load the settle counter with SETTLE_CYCLES-1.
    - SAR: dac_data = 100..0; bit index = BITWIDTH-1.
    - Tracking: dac_data = result.
  - start and stop asserted together in IDLE: stop wins; remain IDLE.
- busy and dac_enable are 1 in SETTLE, DECIDE and DONE.
- SETTLE: decrement the counter each cycle; at 0 go to DECIDE. SETTLE lasts exactly SETTLE_CYCLES cycles.
- DECIDE (one cycle), SAR:
  - comp=0 clears the current bit; comp=1 keeps it.
  - If bit index > 0: also set the next lower bit, decrement the index, go to SETTLE.
  - Else go to DONE.
- DECIDE (one cycle), tracking:
  - comp=1: code+1; comp=0: code-1.
  - Clamp at all-ones and 0. saturated = 1 if a clamp occurred this step, else 0.
  - result ← new code, result_valid = 1 in the next cycle.
  - Go to SETTLE.
- DONE (SAR only, one cycle): result ← dac_data, result_valid = 1, then IDLE.
- SAR latency: result_valid is high in the cycle BITWIDTH*(SETTLE_CYCLES+1)+1 clocks after the edge that accepts start. Defaults give 31.
- Tracking period: SETTLE_CYCLES+1 cycles per result_valid pulse.
- stop while busy (any state):
  - Next cycle: IDLE, busy = 0, dac_enable = 0.
  - No result_valid; result unchanged; dac_data holds.
  - stop coinciding with a DECIDE cycle discards that decision.
- start while busy: ignored. mode changes while busy: ignored.
- saturated updates only in tracking DECIDE; it is cleared on accepting start.
- result_valid is never asserted for two consecutive cycles.
- Async reset mid-operation immediately forces all reset values; no result_valid afterwards.

Test Plan:
- SAR, BITWIDTH=6, SETTLE=4, comparator model comp=(dac_data≤37): start pulse → dac_data sequence 32,48,40,36,38,37 → result=37, result_valid exactly 31 cycles after start, busy low next cycle, dac_enable low in IDLE.
- SAR extremes: comp tied 1 → result=63; comp tied 0 → result=0; every decision phase lasts exactly 5 cycles.
- Tracking from result=32, threshold 35: result_valid every 5 cycles with codes 33,34,35,36,35,36,… ; saturated=0 throughout; stop → busy=0 next cycle, result holds last code.
- Tracking saturation from result=62, comp tied 1 → codes 63,63,63 with saturated=0,1,1. Then comp=0 → 62 with saturated=0. Mirror case: comp tied 0 from result=1 → 0,0 with saturated=1 from the second step.
- Abort and collisions:
  - stop 10 cycles into SAR → no result_valid, result unchanged, dac_enable=0 next cycle.
  - start+stop in the same IDLE cycle → stays IDLE.
  - start during busy → no restart; latency unchanged.
- Reset mid-tracking: rst_n low asynchronously between edges → outputs immediately 32/0/0/0/0. After release, a SAR start converts correctly with no spurious result_valid.
